arch_map_table_param: RTL and testbench

//  Parametrised architectural map table: holds the committed logical->physical

---
 rtl/arch_map_table_param.sv | 146 ++++++++++++++
 tb/tb_arch_map_table_param.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arch_map_table_param.sv
// Architectural (committed) logical->physical map table. Retires up to COMMIT_WIDTH
// destinations per cycle, frees superseded tags, and streams the table to the RMT on recovery.
`timescale 1ns/1ps
module arch_map_table_param #(
   parameter int unsigned COMMIT_WIDTH  = 4,
   parameter int unsigned NUM_LOG       = 32,
   parameter int unsigned LOG_W         = 5,
   parameter int unsigned PHY_W         = 7,
   parameter int unsigned RECOVER_WIDTH = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [COMMIT_WIDTH-1:0]           commit_valid_i,
   input  logic [COMMIT_WIDTH*LOG_W-1:0]     commit_log_i,
   input  logic [COMMIT_WIDTH*PHY_W-1:0]     commit_phy_i,
   input  logic                              recover_start_i,
   output logic [COMMIT_WIDTH-1:0]           released_valid_o,
   output logic [COMMIT_WIDTH*PHY_W-1:0]     released_phy_o,
   output logic [RECOVER_WIDTH-1:0]          recover_valid_o,
   output logic [RECOVER_WIDTH*LOG_W-1:0]    recover_log_o,
   output logic [RECOVER_WIDTH*PHY_W-1:0]    recover_phy_o,
   output logic                              recover_done_o,
   output logic                              busy_o
);

   localparam int unsigned CNT_W = $clog2(NUM_LOG + RECOVER_WIDTH);

   typedef enum logic [1:0] {IDLE, WALK, DONE} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PHY_W-1:0]    table_q [NUM_LOG];
   logic [PHY_W-1:0]    table_d [NUM_LOG];
   logic [COMMIT_WIDTH-1:0] shadow;
   logic [COMMIT_WIDTH-1:0] wr_en;
   logic                commit_en;

   assign commit_en = (state_q == IDLE);

   // A slot is shadowed when a younger valid slot retires the same logical register.
   always_comb begin
      shadow = '0;
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
         for (int unsigned j = k + 1; j < COMMIT_WIDTH; j++) begin
            if (commit_valid_i[j] &&
                (commit_log_i[j*LOG_W +: LOG_W] == commit_log_i[k*LOG_W +: LOG_W]))
               shadow[k] = 1'b1;
         end
      end
   end

   assign wr_en = commit_valid_i & ~shadow & {COMMIT_WIDTH{commit_en}};

   always_comb begin
      released_valid_o = '0;
      released_phy_o   = '0;
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
         if (commit_en && commit_valid_i[k]) begin
            released_valid_o[k] = 1'b1;
            if (shadow[k]) begin
               released_phy_o[k*PHY_W +: PHY_W] = commit_phy_i[k*PHY_W +: PHY_W];
            end else begin
               for (int unsigned i = 0; i < NUM_LOG; i++) begin
                  if (32'(commit_log_i[k*LOG_W +: LOG_W]) == i)
                     released_phy_o[k*PHY_W +: PHY_W] = table_q[i];
               end
            end
         end
      end
   end

   // Non-shadowed writers never share a logical index, so slot order is irrelevant here.
   always_comb begin
      table_d = table_q;
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
         if (wr_en[k]) begin
            for (int unsigned i = 0; i < NUM_LOG; i++) begin
               if (32'(commit_log_i[k*LOG_W +: LOG_W]) == i)
                  table_d[i] = commit_phy_i[k*PHY_W +: PHY_W];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_LOG; i++)
            table_q[i] <= PHY_W'(i);
      end else begin
         table_q <= table_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (recover_start_i) begin
               state_d = WALK;
               cnt_d   = '0;
            end
         end
         WALK: begin
            cnt_d = cnt_q + CNT_W'(RECOVER_WIDTH);
            if ((32'(cnt_q) + RECOVER_WIDTH) >= NUM_LOG)
               state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Lanes past the end of the table in the final group stay zero.
   always_comb begin
      recover_valid_o = '0;
      recover_log_o   = '0;
      recover_phy_o   = '0;
      if (state_q == WALK) begin
         for (int unsigned j = 0; j < RECOVER_WIDTH; j++) begin
            if ((32'(cnt_q) + j) < NUM_LOG) begin
               recover_valid_o[j]             = 1'b1;
               recover_log_o[j*LOG_W +: LOG_W] = LOG_W'(32'(cnt_q) + j);
               for (int unsigned i = 0; i < NUM_LOG; i++) begin
                  if ((32'(cnt_q) + j) == i)
                     recover_phy_o[j*PHY_W +: PHY_W] = table_q[i];
               end
            end
         end
      end
   end

   assign recover_done_o = (state_q == DONE);
   assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_arch_map_table_param.sv
// Directed bench for arch_map_table_param: a 32-entry instance for commit/release/walk
// and a 34-entry instance for the partial final recovery group.
`timescale 1ns/1ps
module tb_arch_map_table_param;

   logic clk, reset;

   // Instance A: NUM_LOG=32, LOG_W=5, PHY_W=7
   logic [3:0]  cvalid_a;
   logic [19:0] clog_a;
   logic [27:0] cphy_a;
   logic        start_a;
   logic [3:0]  relv_a;
   logic [27:0] relp_a;
   logic [3:0]  rvalid_a;
   logic [19:0] rlog_a;
   logic [27:0] rphy_a;
   logic        done_a, busy_a;

   // Instance B: NUM_LOG=34, LOG_W=6, PHY_W=7
   logic [3:0]  cvalid_b;
   logic [23:0] clog_b;
   logic [27:0] cphy_b;
   logic        start_b;
   logic [3:0]  relv_b;
   logic [27:0] relp_b;
   logic [3:0]  rvalid_b;
   logic [23:0] rlog_b;
   logic [27:0] rphy_b;
   logic        done_b, busy_b;

   int vectors = 0;
   int miscompares = 0;

   logic [6:0] seen_a [32];
   int         walk_cycles, done_cycle;

   arch_map_table_param #(
      .COMMIT_WIDTH(4), .NUM_LOG(32), .LOG_W(5), .PHY_W(7), .RECOVER_WIDTH(4)
   ) dut_a (
      .clk(clk), .reset(reset),
      .commit_valid_i(cvalid_a), .commit_log_i(clog_a), .commit_phy_i(cphy_a),
      .recover_start_i(start_a),
      .released_valid_o(relv_a), .released_phy_o(relp_a),
      .recover_valid_o(rvalid_a), .recover_log_o(rlog_a), .recover_phy_o(rphy_a),
      .recover_done_o(done_a), .busy_o(busy_a)
   );

   arch_map_table_param #(
      .COMMIT_WIDTH(4), .NUM_LOG(34), .LOG_W(6), .PHY_W(7), .RECOVER_WIDTH(4)
   ) dut_b (
      .clk(clk), .reset(reset),
      .commit_valid_i(cvalid_b), .commit_log_i(clog_b), .commit_phy_i(cphy_b),
      .recover_start_i(start_b),
      .released_valid_o(relv_b), .released_phy_o(relp_b),
      .recover_valid_o(rvalid_b), .recover_log_o(rlog_b), .recover_phy_o(rphy_b),
      .recover_done_o(done_b), .busy_o(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs a full walk on instance A and records every streamed mapping into seen_a.
   task automatic walk_a(output int wc, output int dc);
      for (int i = 0; i < 32; i++) seen_a[i] = 7'h7f;
      wc = 0;
      dc = 0;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         #1;
         if (done_a) begin
            dc = c;
            break;
         end
         if (busy_a) begin
            wc++;
            for (int j = 0; j < 4; j++)
               if (rvalid_a[j]) seen_a[rlog_a[j*5 +: 5]] = rphy_a[j*7 +: 7];
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cvalid_a = '0; clog_a = '0; cphy_a = '0; start_a = 1'b0;
      cvalid_b = '0; clog_b = '0; cphy_b = '0; start_b = 1'b0;
      #12;
      vectors++;
      if ({busy_a, done_a, relv_a, rvalid_a, rlog_a, rphy_a} !== '0) begin
         miscompares++;
         $display("FAIL reset_a: busy=%b done=%b relv=%b rvalid=%b expected all 0",
                  busy_a, done_a, relv_a, rvalid_a);
      end
      vectors++;
      if ({busy_b, done_b, relv_b, relp_b, rvalid_b} !== '0) begin
         miscompares++;
         $display("FAIL reset_b: busy=%b done=%b relv=%b rvalid=%b expected all 0",
                  busy_b, done_b, relv_b, rvalid_b);
      end
      @(negedge clk); reset = 1'b0;
      #1;
   endtask

   task automatic test_identity_walk();
      @(negedge clk); start_a = 1'b1;
      #1;
      vectors++;
      if (busy_a !== 1'b0) begin
         miscompares++;
         $display("FAIL walk_pre_busy: got %b expected 0", busy_a);
      end
      @(negedge clk); start_a = 1'b0;
      for (int g = 0; g < 8; g++) begin
         #1;
         vectors++;
         if ({busy_a, done_a, rvalid_a} !== 6'b10_1111) begin
            miscompares++;
            $display("FAIL walk_g%0d_ctrl: busy=%b done=%b valid=%b expected 1 0 1111",
                     g, busy_a, done_a, rvalid_a);
         end
         for (int j = 0; j < 4; j++) begin
            vectors++;
            if (rlog_a[j*5 +: 5] !== 5'(4*g+j) || rphy_a[j*7 +: 7] !== 7'(4*g+j)) begin
               miscompares++;
               $display("FAIL walk_g%0d_l%0d: log=%0d phy=%0d expected %0d %0d",
                        g, j, rlog_a[j*5 +: 5], rphy_a[j*7 +: 7], 4*g+j, 4*g+j);
            end
         end
         @(negedge clk);
      end
      #1;
      vectors++;
      if ({done_a, busy_a, rvalid_a} !== 6'b11_0000) begin
         miscompares++;
         $display("FAIL walk_done: done=%b busy=%b valid=%b expected 1 1 0000",
                  done_a, busy_a, rvalid_a);
      end
      @(negedge clk); #1;
      vectors++;
      if ({done_a, busy_a} !== 2'b00) begin
         miscompares++;
         $display("FAIL walk_idle: done=%b busy=%b expected 0 0", done_a, busy_a);
      end
   endtask

   task automatic test_partial_group();
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      for (int g = 0; g < 9; g++) begin
         #1;
         vectors++;
         if (g < 8) begin
            if ({busy_b, done_b, rvalid_b} !== 6'b10_1111 || rlog_b[5:0] !== 6'(4*g)) begin
               miscompares++;
               $display("FAIL part_g%0d: busy=%b done=%b valid=%b log0=%0d expected 1 0 1111 %0d",
                        g, busy_b, done_b, rvalid_b, rlog_b[5:0], 4*g);
            end
         end else begin
            if ({busy_b, done_b, rvalid_b} !== 6'b10_0011) begin
               miscompares++;
               $display("FAIL part_last_valid: busy=%b done=%b valid=%b expected 1 0 0011",
                        busy_b, done_b, rvalid_b);
            end
            vectors++;
            if (rlog_b[5:0] !== 6'd32 || rlog_b[11:6] !== 6'd33 ||
                rphy_b[6:0] !== 7'd32 || rphy_b[13:7] !== 7'd33) begin
               miscompares++;
               $display("FAIL part_last_data: log=%0d,%0d phy=%0d,%0d expected 32,33 32,33",
                        rlog_b[5:0], rlog_b[11:6], rphy_b[6:0], rphy_b[13:7]);
            end
         end
         @(negedge clk);
      end
      #1;
      vectors++;
      if (done_b !== 1'b1) begin
         miscompares++;
         $display("FAIL part_done: got %b expected 1", done_b);
      end
   endtask

   task automatic test_commit_shadow();
      @(negedge clk);
      cvalid_a = 4'b0111;
      clog_a   = {5'd0, 5'd3, 5'd5, 5'd3};
      cphy_a   = {7'd0, 7'd41, 7'd42, 7'd40};
      #1;
      vectors++;
      if (relv_a !== 4'b0111 || relp_a !== {7'd0, 7'd3, 7'd5, 7'd40}) begin
         miscompares++;
         $display("FAIL shadow_release: valid=%b phy=%0d,%0d,%0d,%0d expected 0111 40,5,3,0",
                  relv_a, relp_a[6:0], relp_a[13:7], relp_a[20:14], relp_a[27:21]);
      end
      @(negedge clk); cvalid_a = '0;
      walk_a(walk_cycles, done_cycle);
      vectors++;
      if (seen_a[3] !== 7'd41 || seen_a[5] !== 7'd42 || seen_a[4] !== 7'd4) begin
         miscompares++;
         $display("FAIL shadow_table: r3=%0d r5=%0d r4=%0d expected 41 42 4",
                  seen_a[3], seen_a[5], seen_a[4]);
      end
      vectors++;
      if (walk_cycles != 8 || done_cycle != 9) begin
         miscompares++;
         $display("FAIL shadow_walk_len: walk=%0d done=%0d expected 8 9", walk_cycles, done_cycle);
      end
   endtask

   task automatic test_all_same_dest();
      @(negedge clk);
      cvalid_a = 4'b1111;
      clog_a   = {5'd7, 5'd7, 5'd7, 5'd7};
      cphy_a   = {7'd53, 7'd52, 7'd51, 7'd50};
      #1;
      vectors++;
      if (relv_a !== 4'b1111 || relp_a !== {7'd7, 7'd52, 7'd51, 7'd50}) begin
         miscompares++;
         $display("FAIL same_release: valid=%b phy=%0d,%0d,%0d,%0d expected 1111 50,51,52,7",
                  relv_a, relp_a[6:0], relp_a[13:7], relp_a[20:14], relp_a[27:21]);
      end
      @(negedge clk); cvalid_a = '0;
      walk_a(walk_cycles, done_cycle);
      vectors++;
      if (seen_a[7] !== 7'd53 || seen_a[3] !== 7'd41) begin
         miscompares++;
         $display("FAIL same_table: r7=%0d r3=%0d expected 53 41", seen_a[7], seen_a[3]);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      cvalid_a = 4'b0001; clog_a = {15'd0, 5'd1}; cphy_a = {21'd0, 7'd60};
      start_a  = 1'b1;
      #1;
      vectors++;
      if (relv_a !== 4'b0001 || relp_a[6:0] !== 7'd1) begin
         miscompares++;
         $display("FAIL start_commit_release: valid=%b phy=%0d expected 0001 1", relv_a, relp_a[6:0]);
      end
      @(negedge clk);
      start_a = 1'b0;
      clog_a  = {15'd0, 5'd2}; cphy_a = {21'd0, 7'd70};
      #1;
      vectors++;
      if (rlog_a[9:5] !== 5'd1 || rphy_a[13:7] !== 7'd60) begin
         miscompares++;
         $display("FAIL start_commit_walk: lane1 log=%0d phy=%0d expected 1 60", rlog_a[9:5], rphy_a[13:7]);
      end
      vectors++;
      if (relv_a !== 4'b0000) begin
         miscompares++;
         $display("FAIL busy_release: valid=%b expected 0000", relv_a);
      end
      for (int c = 0; c < 20 && !done_a; c++) begin
         @(negedge clk); #1;
      end
      vectors++;
      if (done_a !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_done_timeout: done=%b expected 1", done_a);
      end
      @(negedge clk);
      cphy_a = {21'd0, 7'd71};
      #1;
      vectors++;
      if (relv_a !== 4'b0001 || relp_a[6:0] !== 7'd2) begin
         miscompares++;
         $display("FAIL busy_no_write: valid=%b phy=%0d expected 0001 2", relv_a, relp_a[6:0]);
      end
      @(negedge clk); cvalid_a = '0;
      walk_a(walk_cycles, done_cycle);
      vectors++;
      if (seen_a[1] !== 7'd60 || seen_a[2] !== 7'd71) begin
         miscompares++;
         $display("FAIL b2b_table: r1=%0d r2=%0d expected 60 71", seen_a[1], seen_a[2]);
      end
   endtask

   task automatic test_reset_mid_walk();
      int spurious;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      vectors++;
      if (busy_a !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_pre: busy=%b expected 1", busy_a);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if ({busy_a, done_a, rvalid_a} !== 6'b0) begin
         miscompares++;
         $display("FAIL midreset_async: busy=%b done=%b valid=%b expected 0 0 0000",
                  busy_a, done_a, rvalid_a);
      end
      @(negedge clk); reset = 1'b0;
      spurious = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (done_a || busy_a) spurious++;
         @(negedge clk);
      end
      vectors++;
      if (spurious != 0) begin
         miscompares++;
         $display("FAIL midreset_no_done: %0d busy/done cycles expected 0", spurious);
      end
      walk_a(walk_cycles, done_cycle);
      vectors++;
      if (seen_a[1] !== 7'd1 || seen_a[2] !== 7'd2 || seen_a[3] !== 7'd3 ||
          seen_a[5] !== 7'd5 || seen_a[7] !== 7'd7) begin
         miscompares++;
         $display("FAIL midreset_identity: r1=%0d r2=%0d r3=%0d r5=%0d r7=%0d expected 1 2 3 5 7",
                  seen_a[1], seen_a[2], seen_a[3], seen_a[5], seen_a[7]);
      end
   endtask

   initial begin
      test_reset();
      test_identity_walk();
      test_partial_group();
      test_commit_shadow();
      test_all_same_dest();
      test_back_to_back();
      test_reset_mid_walk();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
